// File: rtl/majority_vote_pkg.sv
// majority_vote_pkg
//   Shared types and helpers for the majority_vote_ctrl slice.
//   state_t   : session FSM state (IDLE / COLLECT / RESULT), fixed 2-bit encoding.
//   cnt_width : width of a tally able to hold 0..n.
package majority_vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// vote_popcount
//   Combinational population count of an N-bit vector.
//   Parameters: N (vector width), W (result width, must hold 0..N).
//   Ports:
//     i_vec  in  [N-1:0]  vector to count
//     o_cnt  out [W-1:0]  number of ones in i_vec
module vote_popcount #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sum = w_sum + W'(i_vec[i]);
    end
  end

  assign o_cnt = w_sum;

endmodule

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl
//   Timed N-voter session controller. A start in IDLE opens a COLLECT
//   session; each voter's first valid vote is recorded; the session closes
//   when every voter has voted or the timeout window expires, and a single
//   RESULT cycle pulses done with the registered verdict. Tallies, mask,
//   verdict and timed_out hold in IDLE until the next accepted start.
//
//   Optional build macro: MAJORITY_VOTE_EARLY_DECIDE_EN
//     When defined, COLLECT also closes as soon as the verdict can no
//     longer change (pass reached, or pass unreachable with the voters left).
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     start       in   open a session (sampled only in IDLE)
//     vote_valid  in   [N_VOTERS-1:0] per-voter vote strobe
//     vote_yes    in   [N_VOTERS-1:0] per-voter value, qualified by vote_valid
//     busy        out  high in COLLECT and RESULT
//     done        out  one-cycle pulse in RESULT
//     pass        out  registered verdict yes_cnt >= THRESH
//     yes_cnt     out  [CNT_W-1:0] registered yes tally
//     no_cnt      out  [CNT_W-1:0] registered no tally
//     voted_mask  out  [N_VOTERS-1:0] voters that voted this session
//     timed_out   out  session closed by timeout (valid with done, held after)
module majority_vote_ctrl
  import majority_vote_pkg::*;
#(
  parameter  int unsigned N_VOTERS    = 5,
  parameter  int unsigned THRESH      = N_VOTERS / 2 + 1,
  parameter  int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned CNT_W       = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic                timed_out
);

  localparam int unsigned      TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESH);

  state_t              r_state;
  logic [TMR_W-1:0]    r_timer;
  logic [N_VOTERS-1:0] r_mask;
  logic [CNT_W-1:0]    r_yes;
  logic [CNT_W-1:0]    r_no;
  logic                r_done;
  logic                r_pass;
  logic                r_timed_out;

  logic [N_VOTERS-1:0] w_new;
  logic [N_VOTERS-1:0] w_new_yes;
  logic [N_VOTERS-1:0] w_new_no;
  logic [N_VOTERS-1:0] w_mask_nxt;
  logic [CNT_W-1:0]    w_yes_add;
  logic [CNT_W-1:0]    w_no_add;
  logic [CNT_W-1:0]    w_yes_nxt;
  logic [CNT_W-1:0]    w_no_nxt;
  logic                w_all_voted;
  logic                w_tmo;
  logic                w_early;
  logic                w_exit;
  logic                w_tmo_close;

  // Only a voter's first vote in the session counts.
  assign w_new      = vote_valid & ~r_mask;
  assign w_new_yes  = w_new & vote_yes;
  assign w_new_no   = w_new & ~vote_yes;
  assign w_mask_nxt = r_mask | w_new;

  vote_popcount #(.N(N_VOTERS), .W(CNT_W)) u_pc_yes (
    .i_vec (w_new_yes),
    .o_cnt (w_yes_add)
  );

  vote_popcount #(.N(N_VOTERS), .W(CNT_W)) u_pc_no (
    .i_vec (w_new_no),
    .o_cnt (w_no_add)
  );

  // Each voter contributes at most once, so the sums never exceed N_VOTERS.
  assign w_yes_nxt   = r_yes + w_yes_add;
  assign w_no_nxt    = r_no + w_no_add;
  assign w_all_voted = &w_mask_nxt;
  assign w_tmo       = (r_timer == TMO_LAST);

`ifdef MAJORITY_VOTE_EARLY_DECIDE_EN
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N_VOTERS);

  logic [CNT_W-1:0] w_mask_cnt;
  logic [CNT_W-1:0] w_remaining;
  logic [CNT_W:0]   w_reachable;

  vote_popcount #(.N(N_VOTERS), .W(CNT_W)) u_pc_mask (
    .i_vec (w_mask_nxt),
    .o_cnt (w_mask_cnt)
  );

  // Best case yes total if every outstanding voter still votes yes.
  assign w_remaining = N_C - w_mask_cnt;
  assign w_reachable = {1'b0, w_yes_nxt} + {1'b0, w_remaining};
  assign w_early     = (w_yes_nxt >= THR_C) || (w_reachable < {1'b0, THR_C});
`else
  assign w_early     = 1'b0;
`endif

  assign w_exit      = w_all_voted | w_tmo | w_early;
  // Timeout only counts as the cause when no other close condition holds.
  assign w_tmo_close = w_tmo & ~w_all_voted & ~w_early;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_mask      <= '0;
      r_yes       <= '0;
      r_no        <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= COLLECT;
            r_timer     <= '0;
            r_mask      <= '0;
            r_yes       <= '0;
            r_no        <= '0;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
        COLLECT: begin
          r_mask  <= w_mask_nxt;
          r_yes   <= w_yes_nxt;
          r_no    <= w_no_nxt;
          r_timer <= r_timer + 1'b1;
          if (w_exit) begin
            // Verdict and done are registered on the closing edge so both
            // appear together during the single RESULT cycle.
            r_state     <= RESULT;
            r_done      <= 1'b1;
            r_pass      <= (w_yes_nxt >= THR_C);
            r_timed_out <= w_tmo_close;
          end
        end
        RESULT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign yes_cnt    = r_yes;
  assign no_cnt     = r_no;
  assign voted_mask = r_mask;
  assign timed_out  = r_timed_out;

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl
//   Directed and randomized sessions against a per-voter reference model.
//   Inputs change on the falling edge; outputs are compared on the falling
//   edge before the next inputs are applied.
module tb_majority_vote_ctrl;

  localparam int N   = 5;
  localparam int TH  = 3;
  localparam int TMO = 16;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  vote_valid = '0;
  logic [N-1:0]  vote_yes = '0;
  logic          busy, done, pass, timed_out;
  logic [CW-1:0] yes_cnt, no_cnt;
  logic [N-1:0]  voted_mask;

  majority_vote_ctrl #(
    .N_VOTERS    (N),
    .THRESH      (TH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vote_valid (vote_valid),
    .vote_yes   (vote_yes),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .yes_cnt    (yes_cnt),
    .no_cnt     (no_cnt),
    .voted_mask (voted_mask),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Per-cycle vote plan for the next session (index 0 = first COLLECT cycle).
  logic [N-1:0] plan_v [32];
  logic [N-1:0] plan_y [32];
  int           plan_len;

  // Reference model: which voters have voted, and their tallies.
  bit m_voted [N];
  int m_yes, m_no, m_cnt;
  int e_pass, e_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = m_voted[i];
    return m;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_voted[i] = 1'b0;
    m_yes = 0; m_no = 0; m_cnt = 0;
  endtask

  task automatic m_apply(input logic [N-1:0] v, input logic [N-1:0] y);
    for (int i = 0; i < N; i++) begin
      if (v[i] && !m_voted[i]) begin
        m_voted[i] = 1'b1;
        m_cnt++;
        if (y[i]) m_yes++; else m_no++;
      end
    end
  endtask

  task automatic chk_held(input string ph);
    chk({ph, "_yes"},  32'(yes_cnt),    32'(m_yes));
    chk({ph, "_no"},   32'(no_cnt),     32'(m_no));
    chk({ph, "_mask"}, 32'(voted_mask), 32'(m_mask()));
    chk({ph, "_pass"}, 32'(pass),       32'(e_pass));
    chk({ph, "_to"},   32'(timed_out),  32'(e_to));
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 32; i++) begin plan_v[i] = '0; plan_y[i] = '0; end
    plan_len = 0;
  endtask

  task automatic run_session(input bit noisy_start);
    int c;
    bit closed, all_v, early, tmo;
    @(negedge clk);
    start = 1'b1;
    vote_valid = N'($urandom);   // ignored in IDLE
    vote_yes   = N'($urandom);
    @(negedge clk);
    m_clear();
    e_pass = 0; e_to = 0;
    chk("open_busy", 32'(busy), 32'd1);
    chk("open_done", 32'(done), 32'd0);
    chk_held("open");
    closed = 1'b0;
    c = 0;
    while (!closed && c < TMO) begin
      c++;
      vote_valid = (c <= plan_len) ? plan_v[c-1] : '0;
      vote_yes   = (c <= plan_len) ? plan_y[c-1] : '0;
      start      = noisy_start ? 1'($urandom) : 1'b0;
      @(negedge clk);
      m_apply(vote_valid, vote_yes);
      all_v = (m_cnt == N);
      tmo   = (c == TMO);
      early = 1'b0;
`ifdef MAJORITY_VOTE_EARLY_DECIDE_EN
      early = (m_yes >= TH) || (m_yes + (N - m_cnt) < TH);
`endif
      closed = all_v || tmo || early;
      if (closed) begin
        e_pass = (m_yes >= TH) ? 1 : 0;
        e_to   = (tmo && !all_v && !early) ? 1 : 0;
      end
      chk("col_busy", 32'(busy), 32'd1);
      chk("col_done", 32'(done), 32'(closed));
      chk_held("col");
    end
    // RESULT cycle: votes and start must both be ignored.
    vote_valid = N'($urandom);
    vote_yes   = N'($urandom);
    start      = noisy_start;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk_held("idle");
    start = 1'b0;
    vote_valid = N'($urandom);
    @(negedge clk);
    chk("idle2_busy", 32'(busy), 32'd0);
    chk("idle2_done", 32'(done), 32'd0);
    chk_held("idle2");
    vote_valid = '0;
    vote_yes   = '0;
  endtask

  initial begin
    m_clear();
    e_pass = 0; e_to = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_held("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All five vote in the first COLLECT cycle, three yes.
    clear_plan();
    plan_v[0] = 5'b11111; plan_y[0] = 5'b00111; plan_len = 1;
    run_session(1'b0);

    // Voter 0 yes then a repeated no; the rest vote no later.
    clear_plan();
    plan_v[0] = 5'b00001; plan_y[0] = 5'b00001;
    plan_v[1] = 5'b00001; plan_y[1] = 5'b00000;
    plan_v[2] = 5'b00110; plan_y[2] = 5'b00000;
    plan_v[3] = 5'b11000; plan_y[3] = 5'b00000;
    plan_len = 4;
    run_session(1'b0);

    // Only voters 0 and 1 vote yes: closes by timeout.
    clear_plan();
    plan_v[0] = 5'b00011; plan_y[0] = 5'b00011; plan_len = 1;
    run_session(1'b0);

    // Three yes at once, then three no at once.
    clear_plan();
    plan_v[0] = 5'b00111; plan_y[0] = 5'b00111; plan_len = 1;
    run_session(1'b0);
    clear_plan();
    plan_v[0] = 5'b00111; plan_y[0] = 5'b00000; plan_len = 1;
    run_session(1'b1);

    // Reset in the middle of a session after two votes.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote_valid = 5'b00011; vote_yes = 5'b00001;
    @(negedge clk);
    vote_valid = '0; vote_yes = '0;
    chk("pre_rst_mask", 32'(voted_mask), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    m_clear(); e_pass = 0; e_to = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk_held("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Randomized sessions with noisy start.
    for (int s = 0; s < 30; s++) begin
      clear_plan();
      plan_len = TMO;
      for (int c = 0; c < TMO; c++) begin
        plan_v[c] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        plan_y[c] = N'($urandom);
      end
      run_session(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
